alu_wb_stage: RTL and testbench

//   Writeback stage directly downstream of the ALU. Accepts each ALU result with its flags, opcode and

---
 rtl/alu_wb_stage.sv | 137 +++++++++++++
 tb/tb_alu_wb_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU: 2-entry result buffer draining to the register-file write port.
// Optional build macro ALU_WB_STICKY_V_EN makes status[3] (V) sticky and adds the sticky_clr input.
module alu_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_op,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_out,
    input  logic [5:0]         in_flags,
    output logic               rf_we,
    input  logic               rf_ready,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [5:0]         status,
`ifdef ALU_WB_STICKY_V_EN
    input  logic               sticky_clr,
`endif
    output logic [CNT_W-1:0]   retired,
    output logic               op_err
);

    // Flag bit order: {h,s,v,c,n,z}
    localparam logic [5:0] MASK_ZN   = 6'b000011;
    localparam logic [5:0] MASK_ALL  = 6'b111111;
    localparam logic [5:0] MASK_SHFT = 6'b100111;

    logic [4:0]         op_q    [2];
    logic [RADDR_W-1:0] rd_q    [2];
    logic [DATA_W-1:0]  out_q   [2];
    logic [5:0]         flags_q [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;

    logic [4:0]         head_op;
    logic [5:0]         head_flags;
    logic               head_valid;
    logic               head_wr;
    logic               head_illegal;
    logic               head_addsub;
    logic [5:0]         head_mask;
    logic               push;
    logic               pop;
    logic               commit_wr;
    logic [5:0]         status_nxt;

    assign head_op    = op_q[rd_ptr];
    assign head_flags = flags_q[rd_ptr];
    assign head_valid = (count != 2'd0);
    assign in_ready   = (count < 2'd2);
    assign push       = in_valid & in_ready;

    always_comb begin
        head_wr      = 1'b0;
        head_illegal = 1'b0;
        head_addsub  = 1'b0;
        head_mask    = 6'b000000;
        unique case (head_op)
            5'h00: ;
            5'h01: begin head_wr = 1'b1; head_mask = MASK_ZN; end
            5'h03, 5'h04: begin
                head_wr     = 1'b1;
                head_mask   = MASK_ALL;
                head_addsub = 1'b1;
            end
            5'h05, 5'h06, 5'h07, 5'h08: begin head_wr = 1'b1; head_mask = MASK_ZN; end
            5'h09, 5'h0A: begin head_wr = 1'b1; head_mask = MASK_SHFT; end
            default: head_illegal = 1'b1;
        endcase
    end

    assign rf_we     = head_valid & head_wr;
    assign commit_wr = rf_we & rf_ready;
    // NOPs and illegal ops retire immediately without touching the register file
    assign pop       = head_valid & (head_wr ? rf_ready : 1'b1);
    assign rf_waddr  = rf_we ? rd_q[rd_ptr]  : '0;
    assign rf_wdata  = rf_we ? out_q[rd_ptr] : '0;

    always_comb begin
        status_nxt = status;
        if (commit_wr) begin
            status_nxt = (status & ~head_mask) | (head_flags & head_mask);
`ifdef ALU_WB_STICKY_V_EN
            status_nxt[3] = status[3];
            if (head_mask[3]) begin
                if (head_flags[3])
                    status_nxt[3] = 1'b1;
                else if (head_addsub && sticky_clr)
                    status_nxt[3] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                op_q[i]    <= '0;
                rd_q[i]    <= '0;
                out_q[i]   <= '0;
                flags_q[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            status  <= '0;
            retired <= '0;
            op_err  <= 1'b0;
        end else begin
            if (push) begin
                op_q[wr_ptr]    <= in_op;
                rd_q[wr_ptr]    <= in_rd;
                out_q[wr_ptr]   <= in_out;
                flags_q[wr_ptr] <= in_flags;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            status <= status_nxt;
            if (commit_wr)
                retired <= retired + CNT_W'(1);
            op_err <= head_valid & head_illegal;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage, built with CNT_W=4 so the retired counter wraps quickly.
module tb_alu_wb_stage;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_op;
    logic [RADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]  in_out;
    logic [5:0]         in_flags;
    logic               rf_we;
    logic               rf_ready;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [5:0]         status;
    logic [CNT_W-1:0]   retired;
    logic               op_err;
`ifdef ALU_WB_STICKY_V_EN
    logic               sticky_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_out(in_out), .in_flags(in_flags),
        .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .status(status),
`ifdef ALU_WB_STICKY_V_EN
        .sticky_clr(sticky_clr),
`endif
        .retired(retired), .op_err(op_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] rd,
                         input logic [31:0] dat, input logic [5:0] fl);
        in_valid = v;
        in_op    = op;
        in_rd    = rd;
        in_out   = dat;
        in_flags = fl;
    endtask

    initial begin
        rst = 1'b1;
        rf_ready = 1'b1;
        drive(1'b1, 5'h03, 4'd7, 32'hDEAD, 6'h3F);
        step();
        step();
        // T1: reset with in_valid held high
        rst = 1'b0;
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t1_rf_we", rf_we, 1'b0);
        chk("t1_status", status, 6'd0);
        chk("t1_retired", retired, 4'd0);
        chk("t1_in_ready", in_ready, 1'b1);
        chk("t1_waddr", rf_waddr, 4'd0);
        chk("t1_wdata", rf_wdata, 32'd0);
        step();
        chk("t1_no_ghost", rf_we, 1'b0);

        // T2: ADD written one cycle after acceptance
        drive(1'b1, 5'h03, 4'd3, 32'd0, 6'b000101);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t2_rf_we", rf_we, 1'b1);
        chk("t2_waddr", rf_waddr, 4'd3);
        chk("t2_wdata", rf_wdata, 32'd0);
        step();
        chk("t2_status", status, 6'b000101);
        chk("t2_retired", retired, 4'd1);
        chk("t2_idle", rf_we, 1'b0);

        // T3: back-pressure, 3rd result held by source
        rf_ready = 1'b0;
        drive(1'b1, 5'h06, 4'd1, 32'h11, 6'b111111);
        step();
        chk("t3_ready_1", in_ready, 1'b1);
        drive(1'b1, 5'h07, 4'd2, 32'h22, 6'b000000);
        step();
        chk("t3_ready_full", in_ready, 1'b0);
        drive(1'b1, 5'h09, 4'd4, 32'h33, 6'b100010);
        step();
        chk("t3_stall_ready", in_ready, 1'b0);
        chk("t3_stall_waddr", rf_waddr, 4'd1);
        chk("t3_stall_retired", retired, 4'd1);
        chk("t3_stall_status", status, 6'b000101);
        rf_ready = 1'b1;
        step();
        chk("t3_w2_addr", rf_waddr, 4'd2);
        chk("t3_w2_data", rf_wdata, 32'h22);
        chk("t3_w1_retired", retired, 4'd2);
        chk("t3_w1_status", status, 6'b000111);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t3_w3_addr", rf_waddr, 4'd4);
        chk("t3_w3_data", rf_wdata, 32'h33);
        chk("t3_w2_retired", retired, 4'd3);
        chk("t3_w2_status", status, 6'b000100);
        step();
        chk("t3_empty_we", rf_we, 1'b0);
        chk("t3_empty_ready", in_ready, 1'b1);
        chk("t3_retired", retired, 4'd4);
        chk("t3_status", status, 6'b100010);

        // T4: AND with zero flags clears only z,n
        drive(1'b1, 5'h03, 4'd5, 32'h5, 6'h3F);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        step();
        chk("t4_status_all", status, 6'h3F);
        drive(1'b1, 5'h05, 4'd6, 32'hA5A5, 6'h00);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t4_and_wdata", rf_wdata, 32'hA5A5);
        step();
        chk("t4_status", status, 6'b111100);
        chk("t4_retired", retired, 4'd6);

        // T5: illegal op dropped with a single op_err pulse; NOP dropped silently
        drive(1'b1, 5'h1F, 4'd8, 32'h99, 6'h03);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t5_no_we", rf_we, 1'b0);
        chk("t5_err_early", op_err, 1'b0);
        step();
        chk("t5_err_pulse", op_err, 1'b1);
        chk("t5_status", status, 6'b111100);
        chk("t5_retired", retired, 4'd6);
        step();
        chk("t5_err_clear", op_err, 1'b0);
        drive(1'b1, 5'h00, 4'd9, 32'h77, 6'h03);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        chk("t5_nop_no_we", rf_we, 1'b0);
        step();
        chk("t5_nop_no_err", op_err, 1'b0);
        chk("t5_nop_status", status, 6'b111100);
        chk("t5_nop_retired", retired, 4'd6);
        drive(1'b1, 5'h02, 4'd9, 32'h77, 6'h03);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        step();
        chk("t5_op02_err", op_err, 1'b1);

        // T6: retired wraps 15 -> 0 (LD with zero flags leaves status alone here)
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 5'h01, 4'(i), 32'(i), 6'h00);
            step();
            drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
            step();
        end
        chk("t6_retired_max", retired, 4'hF);
        chk("t6_status", status, 6'b111100);
        drive(1'b1, 5'h01, 4'd2, 32'd1, 6'h00);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        step();
        chk("t6_retired_wrap", retired, 4'd0);

        // Reset mid-drain discards buffered entries
        rf_ready = 1'b0;
        drive(1'b1, 5'h03, 4'd1, 32'h1, 6'h3F);
        step();
        drive(1'b1, 5'h03, 4'd2, 32'h2, 6'h3F);
        step();
        drive(1'b0, 5'h00, 4'd0, 32'd0, 6'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rf_ready = 1'b1;
        chk("rst_mid_we", rf_we, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b1);
        step();
        chk("rst_mid_retired", retired, 4'd0);
        chk("rst_mid_status", status, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
